// File: rtl/beam_power_trigger.sv
// beam_power_trigger: windowed beam power compared against double-buffered trigger/servo
// thresholds, with valid-qualified window fill and per-beam trigger holdoff.
module beam_power_trigger #(
    parameter int NBEAMS     = 8,
    parameter int NSAMP      = 8,
    parameter int BEAMBITS   = 8,
    parameter int WINDOW     = 2,
    parameter int THRESHBITS = 18,
    parameter int HOLDBITS   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NBEAMS*NSAMP*BEAMBITS-1:0] beam_i,
    input  logic                             beam_valid_i,
    input  logic [THRESHBITS-1:0]            thresh_i,
    input  logic [NBEAMS-1:0]                thresh_ce_i,
    input  logic                             thresh_sel_i,
    input  logic                             update_i,
    input  logic [HOLDBITS-1:0]              holdoff_i,
    output logic [NBEAMS-1:0]                trigger_o,
    output logic [NBEAMS-1:0]                servo_o
);
    localparam int POWBITS  = 2*BEAMBITS + $clog2(NSAMP) + $clog2(WINDOW) + 1;
    localparam int SQBITS   = 2*BEAMBITS;
    localparam int CMPBITS  = (POWBITS > THRESHBITS) ? POWBITS : THRESHBITS;
    localparam int FILLBITS = $clog2(WINDOW + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    function automatic logic [SQBITS-1:0] square(input logic [BEAMBITS-1:0] x);
        logic signed [SQBITS-1:0] e;
        e = $signed({{BEAMBITS{x[BEAMBITS-1]}}, x});
        return $unsigned(e * e);
    endfunction

    logic [NBEAMS*NSAMP*BEAMBITS-1:0] smp_q, smp_d;
    logic [SQBITS-1:0]     sq_q     [NBEAMS][NSAMP];
    logic [SQBITS-1:0]     sq_d     [NBEAMS][NSAMP];
    logic [POWBITS-1:0]    sum_q    [NBEAMS];
    logic [POWBITS-1:0]    sum_d    [NBEAMS];
    logic [POWBITS-1:0]    hist_q   [NBEAMS][WINDOW];
    logic [POWBITS-1:0]    hist_d   [NBEAMS][WINDOW];
    logic [POWBITS-1:0]    win_q    [NBEAMS];
    logic [POWBITS-1:0]    win_d    [NBEAMS];
    logic [FILLBITS-1:0]   fill_q, fill_d;
    // Stage valids: [0] capture, [1] squares, [2] sums, [3] entered window history
    logic [3:0]            vld_q, vld_d;
    logic                  win_vld_q, win_vld_d;
    logic [THRESHBITS-1:0] pend_a_q [NBEAMS];
    logic [THRESHBITS-1:0] pend_a_d [NBEAMS];
    logic [THRESHBITS-1:0] pend_b_q [NBEAMS];
    logic [THRESHBITS-1:0] pend_b_d [NBEAMS];
    logic [THRESHBITS-1:0] act_a_q  [NBEAMS];
    logic [THRESHBITS-1:0] act_a_d  [NBEAMS];
    logic [THRESHBITS-1:0] act_b_q  [NBEAMS];
    logic [THRESHBITS-1:0] act_b_d  [NBEAMS];
    logic [HOLDBITS-1:0]   cnt_q    [NBEAMS];
    logic [HOLDBITS-1:0]   cnt_d    [NBEAMS];
    logic [NBEAMS-1:0]     state_q, state_d;
    logic [NBEAMS-1:0]     trig_q, trig_d;
    logic [NBEAMS-1:0]     servo_q, servo_d;
    logic [NBEAMS-1:0]     raw_a;

    always_comb begin
        smp_d     = beam_valid_i ? beam_i : '0;
        vld_d     = {vld_q[2:0], beam_valid_i};
        fill_d    = (vld_q[2] && fill_q != FILLBITS'(WINDOW)) ? fill_q + FILLBITS'(1) : fill_q;
        win_vld_d = vld_q[3] && fill_q == FILLBITS'(WINDOW);
        raw_a     = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            sum_d[b] = '0;
            win_d[b] = '0;
            for (int k = 0; k < NSAMP; k++) begin
                sq_d[b][k] = square(smp_q[(b*NSAMP+k)*BEAMBITS +: BEAMBITS]);
                sum_d[b]   = sum_d[b] + POWBITS'(sq_q[b][k]);
            end
            hist_d[b][0] = vld_q[2] ? sum_q[b] : hist_q[b][0];
            for (int w = 1; w < WINDOW; w++)
                hist_d[b][w] = vld_q[2] ? hist_q[b][w-1] : hist_q[b][w];
            for (int w = 0; w < WINDOW; w++)
                win_d[b] = win_d[b] + hist_q[b][w];
            pend_a_d[b] = (thresh_ce_i[b] && !thresh_sel_i) ? thresh_i : pend_a_q[b];
            pend_b_d[b] = (thresh_ce_i[b] &&  thresh_sel_i) ? thresh_i : pend_b_q[b];
            act_a_d[b]  = update_i ? pend_a_d[b] : act_a_q[b];
            act_b_d[b]  = update_i ? pend_b_d[b] : act_b_q[b];
            raw_a[b]    = win_vld_q && (CMPBITS'(win_q[b]) > CMPBITS'(act_a_q[b]));
            servo_d[b]  = win_vld_q && (CMPBITS'(win_q[b]) > CMPBITS'(act_b_q[b]));
            trig_d[b]   = (state_q[b] == IDLE) && raw_a[b];
            state_d[b]  = (state_q[b] == IDLE) ? ((raw_a[b] && holdoff_i != '0) ? HOLD : IDLE)
                                               : ((cnt_q[b] == HOLDBITS'(1)) ? IDLE : HOLD);
            cnt_d[b]    = (state_q[b] == IDLE) ? ((raw_a[b] && holdoff_i != '0) ? holdoff_i : cnt_q[b])
                                               : cnt_q[b] - HOLDBITS'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_q     <= '0;
            sq_q      <= '{default: '0};
            sum_q     <= '{default: '0};
            hist_q    <= '{default: '0};
            win_q     <= '{default: '0};
            fill_q    <= '0;
            vld_q     <= '0;
            win_vld_q <= 1'b0;
            pend_a_q  <= '{default: '1};
            pend_b_q  <= '{default: '1};
            act_a_q   <= '{default: '1};
            act_b_q   <= '{default: '1};
            cnt_q     <= '{default: '0};
            state_q   <= '0;
            trig_q    <= '0;
            servo_q   <= '0;
        end else begin
            smp_q     <= smp_d;
            sq_q      <= sq_d;
            sum_q     <= sum_d;
            hist_q    <= hist_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            vld_q     <= vld_d;
            win_vld_q <= win_vld_d;
            pend_a_q  <= pend_a_d;
            pend_b_q  <= pend_b_d;
            act_a_q   <= act_a_d;
            act_b_q   <= act_b_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            trig_q    <= trig_d;
            servo_q   <= servo_d;
        end
    end

    assign trigger_o = trig_q;
    assign servo_o   = servo_q;
endmodule

// File: tb/tb_beam_power_trigger.sv
// tb_beam_power_trigger: table-driven and hand-written sequences against a scoreboard of
// expected window powers, with thresholds and holdoff modelled at the compare slot.
module tb_beam_power_trigger;
    localparam int NB = 8, NS = 8, BB = 8, TB = 18, HB = 4, PB = 21;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NB*NS*BB-1:0] beam_i = '0;
    logic              beam_valid_i = 1'b0;
    logic [TB-1:0]     thresh_i = '0;
    logic [NB-1:0]     thresh_ce_i = '0;
    logic              thresh_sel_i = 1'b0;
    logic              update_i = 1'b0;
    logic [HB-1:0]     holdoff_i = '0;
    logic [NB-1:0]     trigger_o, servo_o;

    beam_power_trigger #(
        .NBEAMS(NB), .NSAMP(NS), .BEAMBITS(BB), .WINDOW(2), .THRESHBITS(TB), .HOLDBITS(HB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .beam_i(beam_i), .beam_valid_i(beam_valid_i),
        .thresh_i(thresh_i), .thresh_ce_i(thresh_ce_i), .thresh_sel_i(thresh_sel_i),
        .update_i(update_i), .holdoff_i(holdoff_i), .trigger_o(trigger_o), .servo_o(servo_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 ok;
        logic [NB-1:0][PB-1:0] pow;
    } sb_t;

    typedef struct {
        logic [7:0]    v;
        logic [7:0]    oth;
        logic [TB-1:0] tha;
        logic [TB-1:0] thb;
        logic [HB-1:0] hold;
        bit            tog;
        bit            wt;
        int            n;
        int            et;
        int            es;
    } vec_t;

    sb_t           sbq[$];
    vec_t          tbl[8];
    logic [7:0]    vals[NB];
    logic [TB-1:0] pa[NB], pb[NB], aa[NB], ab[NB];
    logic [PB-1:0] prevp[NB];
    logic [HB-1:0] hcnt[NB];
    logic [NB-1:0] hold;
    int            vcnt;
    int            n_cmp = 0, n_bad = 0, cnt_t = 0, cnt_s = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PB-1:0] power(input logic [7:0] v);
        int  s;
        byte x;
        s = 0;
        for (int k = 0; k < NS; k++) begin
            x = k[0] ? -v : v;
            s += int'(x) * int'(x);
        end
        return PB'(s);
    endfunction

    task automatic model_reset();
        sbq.delete();
        repeat (5) sbq.push_back('0);
        for (int b = 0; b < NB; b++) begin
            pa[b] = '1; pb[b] = '1; aa[b] = '1; ab[b] = '1;
            prevp[b] = '0; hcnt[b] = '0;
        end
        hold = '0;
        vcnt = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        beam_valid_i = 1'b0;
        thresh_ce_i = '0;
        update_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    // One clock: push this edge's sample, pop the one whose result appears on this edge.
    task automatic step();
        sb_t           e, o;
        logic [NB-1:0] et, es;
        logic          raw;
        logic [PB-1:0] cur;
        et = '0;
        es = '0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < NS; k++)
                beam_i[(b*NS+k)*BB +: BB] = k[0] ? -vals[b] : vals[b];
        e = '0;
        if (beam_valid_i) begin
            vcnt = (vcnt < 2) ? vcnt + 1 : 2;
            e.ok = (vcnt == 2);
            for (int b = 0; b < NB; b++) begin
                cur = power(vals[b]);
                e.pow[b] = cur + prevp[b];
                prevp[b] = cur;
            end
        end
        sbq.push_back(e);
        o = sbq.pop_front();
        for (int b = 0; b < NB; b++) begin
            raw = o.ok && (o.pow[b] > {3'b000, aa[b]});
            es[b] = o.ok && (o.pow[b] > {3'b000, ab[b]});
            if (!hold[b]) begin
                et[b] = raw;
                if (raw && holdoff_i != 0) begin
                    hold[b] = 1'b1;
                    hcnt[b] = holdoff_i;
                end
            end else begin
                hcnt[b] = hcnt[b] - 4'd1;
                if (hcnt[b] == 0) hold[b] = 1'b0;
            end
            if (thresh_ce_i[b]) begin
                if (thresh_sel_i) pb[b] = thresh_i;
                else pa[b] = thresh_i;
            end
            if (update_i) begin
                aa[b] = pa[b];
                ab[b] = pb[b];
            end
        end
        @(posedge clk);
        #1;
        check("trigger", 32'(trigger_o), 32'(et));
        check("servo", 32'(servo_o), 32'(es));
        cnt_t += int'(trigger_o[3]);
        cnt_s += int'(servo_o[3]);
    endtask

    task automatic run_vec(input int idx, input vec_t r);
        do_reset();
        cnt_t = 0;
        cnt_s = 0;
        holdoff_i = r.hold;
        for (int b = 0; b < NB; b++) vals[b] = (b == 3) ? r.v : r.oth;
        thresh_ce_i = 8'h08; thresh_sel_i = 1'b1; thresh_i = r.thb; step();
        thresh_sel_i = 1'b0; thresh_i = r.tha; update_i = r.wt; step();
        thresh_ce_i = '0; update_i = !r.wt; step();
        update_i = 1'b0;
        for (int i = 0; i < r.n; i++) begin
            beam_valid_i = r.tog ? (i % 2 == 0) : 1'b1;
            step();
        end
        beam_valid_i = 1'b0;
        repeat (6) step();
        check($sformatf("vec%0d_trig_count", idx), 32'(cnt_t), 32'(r.et));
        check($sformatf("vec%0d_servo_count", idx), 32'(cnt_s), 32'(r.es));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        bit found;
        //          v      oth    A           B           hold  tog   wt    n   et  es
        tbl[0] = '{8'd10,  8'd0, 18'd1599,   18'd262143, 4'd0, 1'b0, 1'b0, 10, 9,  0};
        tbl[1] = '{8'd10,  8'd3, 18'd1600,   18'd1599,   4'd0, 1'b0, 1'b0, 10, 0,  9};
        tbl[2] = '{8'd10,  8'd0, 18'd1599,   18'd0,      4'd4, 1'b0, 1'b0, 16, 3,  15};
        tbl[3] = '{8'h80,  8'd0, 18'd262143, 18'd262143, 4'd0, 1'b0, 1'b0, 6,  5,  5};
        tbl[4] = '{8'h80,  8'd0, 18'd262143, 18'd0,      4'd0, 1'b1, 1'b0, 10, 4,  4};
        tbl[5] = '{8'd10,  8'd0, 18'd0,      18'd262143, 4'd0, 1'b0, 1'b1, 6,  5,  0};
        tbl[6] = '{8'd3,   8'd5, 18'd143,    18'd144,    4'd0, 1'b0, 1'b0, 5,  4,  0};
        tbl[7] = '{8'hF6,  8'd1, 18'd0,      18'd0,      4'd1, 1'b0, 1'b0, 9,  4,  8};
        for (int b = 0; b < NB; b++) vals[b] = '0;

        do_reset();
        check("reset_trig", 32'(trigger_o), 0);
        check("reset_servo", 32'(servo_o), 0);

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Pending load without update must not reach the compare until update.
        do_reset();
        holdoff_i = '0;
        for (int b = 0; b < NB; b++) vals[b] = (b == 3) ? 8'd10 : 8'd0;
        thresh_ce_i = 8'h08; thresh_sel_i = 1'b0; thresh_i = '0; step();
        thresh_ce_i = '0;
        beam_valid_i = 1'b1;
        repeat (8) step();
        check("no_update_trig", 32'(trigger_o[3]), 0);
        update_i = 1'b1; step(); update_i = 1'b0;
        check("update_edge_trig", 32'(trigger_o[3]), 0);
        step();
        check("update_next_trig", 32'(trigger_o[3]), 1);

        // Asynchronous reset mid-stream.
        #3 rst_ni = 1'b0;
        #1;
        check("midrst_trig", 32'(trigger_o), 0);
        check("midrst_servo", 32'(servo_o), 0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        model_reset();
        cnt_t = 0;
        repeat (10) step();
        check("post_rst_no_trig", 32'(cnt_t), 0);

        // Latency from the second valid sample after a fresh reset and reload.
        do_reset();
        thresh_ce_i = 8'h08; thresh_sel_i = 1'b0; thresh_i = 18'd1599; step();
        thresh_ce_i = '0; update_i = 1'b1; step(); update_i = 1'b0;
        beam_valid_i = 1'b1;
        step();
        step();
        lat = 0;
        found = 1'b0;
        for (int i = 1; i <= 10 && !found; i++) begin
            step();
            if (trigger_o[3]) begin
                lat = i;
                found = 1'b1;
            end
        end
        check("first_trig_latency", 32'(lat), 5);
        beam_valid_i = 1'b0;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
